// File: rtl/game_cpu_pkg.sv
// Shared types and constants for the Flappy Bird game-logic engine:
// GPU draw command layout, palette, physics constants and FSM states.
package game_cpu_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] width;
        logic [10:0] height;
        logic [11:0] color;
    } gpu_op_t;

    typedef logic signed [11:0] pos_t;

    typedef enum logic [1:0] {
        ST_UPDATE,
        ST_DRAW,
        ST_WAIT_SWAP
    } state_e;

    localparam logic [11:0] COL_SKY       = 12'h6CF;
    localparam logic [11:0] COL_PIPE      = 12'h0A0;
    localparam logic [11:0] COL_BIRD      = 12'hFF0;
    localparam logic [11:0] COL_BIRD_DEAD = 12'hF00;

    localparam pos_t ZERO       = 12'sd0;
    localparam pos_t BIRD_X     = 12'sd100;
    localparam pos_t BIRD_SIZE  = 12'sd16;
    localparam pos_t PIPE_W     = 12'sd40;
    localparam pos_t GAP        = 12'sd120;
    localparam pos_t GAP_MIN    = 12'sd40;
    localparam pos_t PIPE_SPEED = 12'sd2;
    localparam pos_t GRAVITY    = 12'sd1;
    localparam pos_t FLAP_V     = -12'sd8;
    localparam pos_t VMAX       = 12'sd8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/game_cpu_if.sv
// Write port into the GPU command FIFO: command word, write strobe, full flag.
interface game_cpu_if;
    import game_cpu_pkg::*;

    gpu_op_t op;
    logic    op_wr_en;
    logic    op_full;

    modport master (output op, output op_wr_en, input op_full);
    modport slave  (input op, input op_wr_en, output op_full);
endinterface

// File: rtl/game_cpu_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), stepped on enable.
module game_cpu_lfsr16
    import game_cpu_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [7:0] rnd_o
);
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= SEED;
        else if (en_i)
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign rnd_o = lfsr_q[7:0];
endmodule

// File: rtl/game_cpu.sv
// Per-frame game engine: one UPDATE cycle of physics, six clipped rectangle
// draw commands into the GPU FIFO, then idle until the display swaps buffers.
module game_cpu
    import game_cpu_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       btn,
    input  logic       swap,
    game_cpu_if.master gpu,
    output logic       status_lose,
    output logic       status_wait_gpu,
    output logic       status_wait_swap
);
    localparam pos_t HOR      = pos_t'(HOR_ACTIVE_PIXELS);
    localparam pos_t VER      = pos_t'(VER_ACTIVE_PIXELS);
    localparam pos_t BIRD_Y0  = pos_t'(VER_ACTIVE_PIXELS / 2 - 8);
    localparam pos_t PIPE1_X0 = pos_t'(HOR_ACTIVE_PIXELS + (HOR_ACTIVE_PIXELS + 40) / 2);
    localparam pos_t GAP_TOP0 = pos_t'((VER_ACTIVE_PIXELS - 120) / 2);

    state_e     state_q;
    logic [2:0] idx_q;
    pos_t       bird_y_q, vel_q;
    pos_t       pipe_x_q [2];
    pos_t       gap_q    [2];
    logic       lose_q, flap_q, btn_q;

    pos_t       vel_inc, vel_d, bird_y_d;
    pos_t       pipe_x_d [2];
    pos_t       gap_d    [2];
    logic       lose_d;
    gpu_op_t    op_d;
    logic [7:0] rnd;
    logic       btn_rise, draw_wr;

    game_cpu_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ce && state_q == ST_UPDATE),
        .rnd_o (rnd)
    );

    // Clip a rectangle horizontally to [0, HOR); zero-width results are kept.
    function automatic gpu_op_t clip_op(pos_t x, pos_t w, logic [10:0] y,
                                        logic [10:0] h, logic [11:0] c);
        pos_t cx, cw;
        cx = x;
        cw = w;
        if (cx < ZERO) begin
            cw = cw + cx;
            cx = ZERO;
        end
        if (cx >= HOR) begin
            cx = HOR;
            cw = ZERO;
        end
        if (cx + cw > HOR)
            cw = HOR - cx;
        return '{x: cx[10:0], y: y, width: cw[10:0], height: h, color: c};
    endfunction

    always_comb begin
        vel_inc  = vel_q + GRAVITY;
        vel_d    = flap_q ? FLAP_V : ((vel_inc > VMAX) ? VMAX : vel_inc);
        bird_y_d = bird_y_q + vel_d;
        lose_d   = (bird_y_d < ZERO) || (bird_y_d + BIRD_SIZE > VER);
        for (int p = 0; p < 2; p++) begin
            pipe_x_d[p] = pipe_x_q[p] - PIPE_SPEED;
            gap_d[p]    = gap_q[p];
            if (pipe_x_d[p] + PIPE_W <= ZERO) begin
                pipe_x_d[p] = HOR;
                gap_d[p]    = GAP_MIN + pos_t'({4'd0, rnd});
            end
            if (pipe_x_d[p] < BIRD_X + BIRD_SIZE && pipe_x_d[p] + PIPE_W > BIRD_X &&
                (bird_y_d < gap_d[p] || bird_y_d + BIRD_SIZE > gap_d[p] + GAP))
                lose_d = 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0: op_d = clip_op(ZERO, HOR, 11'd0, 11'(VER), COL_SKY);
            3'd1: op_d = clip_op(pipe_x_q[0], PIPE_W, 11'd0, 11'(gap_q[0]), COL_PIPE);
            3'd2: op_d = clip_op(pipe_x_q[0], PIPE_W, 11'(gap_q[0] + GAP),
                                 11'(VER - gap_q[0] - GAP), COL_PIPE);
            3'd3: op_d = clip_op(pipe_x_q[1], PIPE_W, 11'd0, 11'(gap_q[1]), COL_PIPE);
            3'd4: op_d = clip_op(pipe_x_q[1], PIPE_W, 11'(gap_q[1] + GAP),
                                 11'(VER - gap_q[1] - GAP), COL_PIPE);
            default: op_d = clip_op(BIRD_X, BIRD_SIZE, 11'(bird_y_q), 11'(BIRD_SIZE),
                                    lose_q ? COL_BIRD_DEAD : COL_BIRD);
        endcase
    end

    assign btn_rise         = btn && !btn_q;
    assign draw_wr          = !rst && ce && state_q == ST_DRAW && !gpu.op_full;
    assign gpu.op           = op_d;
    assign gpu.op_wr_en     = draw_wr;
    assign status_wait_gpu  = !rst && state_q == ST_DRAW && gpu.op_full;
    assign status_wait_swap = state_q == ST_WAIT_SWAP;
    assign status_lose      = lose_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DRAW;
            idx_q       <= 3'd0;
            btn_q       <= 1'b0;
            flap_q      <= 1'b0;
            lose_q      <= 1'b0;
            bird_y_q    <= BIRD_Y0;
            vel_q       <= ZERO;
            pipe_x_q[0] <= HOR;
            pipe_x_q[1] <= PIPE1_X0;
            gap_q[0]    <= GAP_TOP0;
            gap_q[1]    <= GAP_TOP0;
        end else if (ce) begin
            btn_q <= btn;
            if (btn_rise)
                flap_q <= 1'b1;
            case (state_q)
                ST_UPDATE: begin
                    // an edge arriving in this very cycle stays pending for next frame
                    flap_q <= btn_rise;
                    if (!lose_q) begin
                        vel_q       <= vel_d;
                        bird_y_q    <= bird_y_d;
                        pipe_x_q[0] <= pipe_x_d[0];
                        pipe_x_q[1] <= pipe_x_d[1];
                        gap_q[0]    <= gap_d[0];
                        gap_q[1]    <= gap_d[1];
                        lose_q      <= lose_d;
                    end else if (flap_q) begin
                        lose_q      <= 1'b0;
                        bird_y_q    <= BIRD_Y0;
                        vel_q       <= ZERO;
                        pipe_x_q[0] <= HOR;
                        pipe_x_q[1] <= PIPE1_X0;
                        gap_q[0]    <= GAP_TOP0;
                        gap_q[1]    <= GAP_TOP0;
                    end
                    state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (draw_wr) begin
                        if (idx_q == 3'd5) begin
                            idx_q   <= 3'd0;
                            state_q <= ST_WAIT_SWAP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                ST_WAIT_SWAP: if (swap) state_q <= ST_UPDATE;
                default: state_q <= ST_DRAW;
            endcase
        end
    end
endmodule

// File: tb/tb_game_cpu.sv
// Directed bench for game_cpu: frame command lists, FIFO back-pressure,
// bird physics, lose/restart, clock-enable hold and mid-frame reset.
module tb_game_cpu;
    import game_cpu_pkg::*;

    logic clk = 1'b0, rst = 1'b1, ce = 1'b0, btn = 1'b0, swap = 1'b0;
    logic lose, wgpu, wswap;

    game_cpu_if gpu_if();

    game_cpu dut (
        .clk              (clk),
        .rst              (rst),
        .ce               (ce),
        .btn              (btn),
        .swap             (swap),
        .gpu              (gpu_if),
        .status_lose      (lose),
        .status_wait_gpu  (wgpu),
        .status_wait_swap (wswap)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    gpu_op_t ops [6];
    int n, cyc, stall_seen, hold_bad;
    int ytab [8] = '{233, 235, 238, 242, 247, 253, 260, 268};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic gpu_op_t eop(input int x, input int y, input int w, input int h,
                                    input logic [11:0] c);
        gpu_op_t o;
        o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h); o.color = c;
        return o;
    endfunction

    // Collects one frame's six ops; op_full/swap high in [slo,shi), ce low in [clo,chi).
    task automatic run_frame(input int slo, input int shi, input int clo, input int chi);
        gpu_op_t held;
        logic    have_held;
        n = 0; cyc = 0; stall_seen = 0; hold_bad = 0; have_held = 1'b0; held = '0;
        while (n < 6 && cyc < 80) begin
            gpu_if.op_full = (cyc >= slo && cyc < shi);
            swap           = gpu_if.op_full;
            ce             = !(cyc >= clo && cyc < chi);
            @(negedge clk);
            if (gpu_if.op_wr_en) begin
                ops[n] = gpu_if.op;
                n++;
            end
            if (gpu_if.op_full && wgpu && !gpu_if.op_wr_en) stall_seen++;
            if (!ce) begin
                if (!have_held) begin
                    held = gpu_if.op;
                    have_held = 1'b1;
                end
                if (gpu_if.op_wr_en || gpu_if.op !== held || wswap || wgpu) hold_bad++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        gpu_if.op_full = 1'b0; swap = 1'b0; ce = 1'b1; #1;
    endtask

    task automatic pulse_swap();
        @(posedge clk); #1 swap = 1'b1;
        @(posedge clk); #1 swap = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, dybad, flaps, y, prev_y;
        logic prev_lose, rose;

        gpu_if.op_full = 1'b0;
        rst = 1'b1; ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", gpu_if.op_wr_en, 0);
        chk("rst_status", {lose, wgpu, wswap}, 0);
        rst = 1'b0;

        run_frame(99, 99, 99, 99);
        chk("f0_n", n, 6);
        chk("f0_cycles", cyc, 6);
        chk("f0_op0", ops[0], eop(0, 0, 640, 480, COL_SKY));
        chk("f0_op1", ops[1], eop(640, 0, 0, 180, COL_PIPE));
        chk("f0_op2", ops[2], eop(640, 300, 0, 180, COL_PIPE));
        chk("f0_op3", ops[3], eop(640, 0, 0, 180, COL_PIPE));
        chk("f0_op5", ops[5], eop(100, 232, 16, 16, COL_BIRD));
        chk("f0_wait_swap", wswap, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("wait_swap_hold", {wswap, gpu_if.op_wr_en}, 2'b10);

        bad = 0;
        for (int f = 1; f <= 33; f++) begin
            pulse_swap();
            if (f == 1) run_frame(2, 7, 99, 99);
            else        run_frame(99, 99, 99, 99);
            if (n != 6 || !wswap) bad++;
            if (f == 1) begin
                chk("f1_stall_cycles", stall_seen, 5);
                chk("f1_cycles", cyc, 11);
                chk("f1_op0", ops[0], eop(0, 0, 640, 480, COL_SKY));
                chk("f1_op1", ops[1], eop(638, 0, 2, 180, COL_PIPE));
                chk("f1_op2", ops[2], eop(638, 300, 2, 180, COL_PIPE));
                chk("f1_op3", ops[3], eop(640, 0, 0, 180, COL_PIPE));
            end
            if (f <= 8) chk($sformatf("fall_y_f%0d", f), ops[5].y, ytab[f-1]);
            if (f == 32) chk("lose_f32", lose, 0);
            if (f == 33) begin
                chk("lose_f33", lose, 1);
                chk("f33_bird", ops[5], eop(100, 468, 16, 16, COL_BIRD_DEAD));
            end
        end
        chk("fall_frames_bad", bad, 0);

        pulse_swap();
        run_frame(99, 99, 99, 99);
        chk("lost_bird_frozen", ops[5], eop(100, 468, 16, 16, COL_BIRD_DEAD));
        chk("lost_pipe_frozen", ops[1], eop(574, 0, 40, 180, COL_PIPE));

        btn = 1'b1;
        pulse_swap();
        run_frame(99, 99, 99, 99);
        chk("restart_lose", lose, 0);
        chk("restart_bird", ops[5], eop(100, 232, 16, 16, COL_BIRD));
        chk("restart_pipe0", ops[1], eop(640, 0, 0, 180, COL_PIPE));
        chk("restart_pipe1", ops[3], eop(640, 0, 0, 180, COL_PIPE));

        btn = 1'b0;
        pulse_swap();
        run_frame(99, 99, 99, 99);
        chk("post_restart_y", ops[5].y, 233);
        btn = 1'b1;
        pulse_swap();
        run_frame(99, 99, 99, 99);
        chk("flap_y", ops[5].y, 225);

        pulse_swap();
        run_frame(99, 99, 2, 22);
        chk("ce_n", n, 6);
        chk("ce_cycles", cyc, 26);
        chk("ce_hold_bad", hold_bad, 0);
        chk("ce_op2", ops[2], eop(634, 300, 6, 180, COL_PIPE));
        chk("ce_bird_y", ops[5].y, 218);

        bad = 0; dybad = 0; flaps = 0;
        prev_y = int'(ops[5].y); prev_lose = lose;
        for (int f = 0; f < 1000; f++) begin
            btn  = (f % 2 == 1);
            rose = (f % 2 == 1);
            pulse_swap();
            run_frame(99, 99, 99, 99);
            if (n != 6 || !wswap) bad++;
            y = int'(ops[5].y);
            if (rose && !prev_lose && !lose) begin
                flaps++;
                if (y - prev_y != -8) dybad++;
            end
            prev_y = y; prev_lose = lose;
        end
        chk("long_frames_bad", bad, 0);
        chk("long_flap_dy_bad", dybad, 0);
        chk("long_flaps_seen", flaps > 0, 1);

        btn = 1'b0;
        pulse_swap();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst_out", {gpu_if.op_wr_en, wswap, lose, wgpu}, 0);
        @(posedge clk); #1 rst = 1'b0;
        run_frame(99, 99, 99, 99);
        chk("midrst_cycles", cyc, 6);
        chk("midrst_op0", ops[0], eop(0, 0, 640, 480, COL_SKY));
        chk("midrst_op1", ops[1], eop(640, 0, 0, 180, COL_PIPE));
        chk("midrst_bird", ops[5], eop(100, 232, 16, 16, COL_BIRD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_cpu.md
Name: game_cpu

Overview:
Game-logic engine for the Flappy Bird design. Once per video frame it updates bird physics, scrolls two pipes and detects collisions. It then emits a fixed list of six rectangle-draw commands into the GPU command FIFO and waits for a frame-buffer swap pulse. It sits between the button input, the GPU op FIFO and the display swap logic.

Parameters:
HOR_ACTIVE_PIXELS, 640, screen width in pixels (≤1023)
VER_ACTIVE_PIXELS, 480, screen height in pixels (≥440, ≤1023)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ce  in  1  clock enable; when 0, all state holds and op_wr_en=0
btn  in  1  flap button, synchronous level
swap  in  1  one-cycle pulse: displayed frame swapped, start next frame
op  out  gpu_op_t  draw command, valid when op_wr_en=1
op_wr_en  out  1  FIFO write strobe; asserted only when op_full=0
op_full  in  1  GPU FIFO full
status_lose  out  1  game over flag
status_wait_gpu  out  1  command pending but op_full=1
status_wait_swap  out  1  frame done, waiting for swap

Behaviour:
- Constants: BIRD_X=100, BIRD_SIZE=16, PIPE_W=40, GAP=120, PIPE_SPEED=2, GRAVITY=1, FLAP_V=-8, VMAX=8. Colours: SKY=12'h6CF, PIPE=12'h0A0, BIRD=12'hFF0, BIRD_DEAD=12'hF00.
- Positions and velocity are signed 12-bit.
- FSM states: UPDATE, DRAW, WAIT_SWAP.
- Reset state: DRAW, op index 0.
  - bird_y=VER/2-8=232; vel=0; lose=0; flap_req=0.
  - pipe0.x=HOR (640); pipe1.x=HOR+(HOR+PIPE_W)/2 (980); both gap_top=(VER-GAP)/2 (180).
  - LFSR=16'hACE1.
  - Outputs 0.
- btn: registered; a rising edge sets flap_req in any state. flap_req is cleared only in UPDATE.
- UPDATE (1 cycle), while not lost:
  - vel = flap_req ? FLAP_V : min(vel+GRAVITY, VMAX); then bird_y += new vel.
  - Each pipe: x -= PIPE_SPEED. If x+PIPE_W ≤ 0, x = HOR and gap_top = 40 + LFSR[7:0].
  - LFSR (x^16+x^14+x^13+x^11+1, Fibonacci) steps once.
  - lose set if bird_y<0, or bird_y+16>VER, or bird rect overlaps a pipe horizontally (x < BIRD_X+16 and x+PIPE_W > BIRD_X) while bird_y<gap_top or bird_y+16>gap_top+GAP.
- UPDATE while lost: no motion. If flap_req, restore all reset game values (LFSR keeps running). Then go to DRAW.
- DRAW: six ops in order, op index advancing only on an accepted write (op_wr_en=1):
  - op0: background 0,0,HOR,VER,SKY.
  - op1, op3: pipe top rects x,0,PIPE_W,gap_top.
  - op2, op4: pipe bottom rects x,gap_top+GAP,PIPE_W,VER-gap_top-GAP.
  - op5: bird BIRD_X,bird_y,16,16, colour BIRD or BIRD_DEAD when lose.
- Horizontal clipping:
  - if x<0: w+=x, x=0.
  - if x≥HOR: x=HOR, w=0.
  - if x+w>HOR: w=HOR-x.
  - Zero-width ops are still emitted.
- op_wr_en = DRAW & ce & !op_full.
- status_wait_gpu = DRAW & op_full.
- After op5 is accepted, go to WAIT_SWAP.
- WAIT_SWAP: status_wait_swap=1. swap=1 → UPDATE next cycle. swap in any other state is ignored.
- status_lose mirrors the lose register.
- Reset mid-frame aborts immediately to reset state.

Decomposition:
- Shared file gpu_op_t.sv holds gpu_op_t, a packed struct of x[10:0], y[10:0], width[10:0], height[10:0], color[11:0] (56 bits), plus the colour constants.
- One natural sub-module: cpu_lfsr16 (enable, seed).
- Clipping is a function inside game_cpu.

Test Plan:
- Reset, ce=1, op_full=0 → six consecutive op_wr_en cycles:
  - op0 = {0,0,640,480,6CF}.
  - op1 = {640,0,0,180}.
  - op2 = {640,300,0,180}.
  - op5 = {100,232,16,16,FF0}.
  - Then status_wait_swap=1 and stays high until swap.
- Hold op_full=1 during DRAW → op_wr_en=0, status_wait_gpu=1, op index frozen. Release → emission resumes at the same op with no drop or duplicate.
- No btn, swap pulsed after each wait_swap:
  - Bird op y after frames 1..8 = 233,235,238,242,247,253,260,268.
  - status_lose rises on the 33rd UPDATE; bird colour F00.
- Toggle btn every frame (the bench pattern) → each rising edge gives vel=-8 the next UPDATE. Run 1000 frames: status_wait_swap recurs every frame and no hang occurs.
- After lose, btn rising edge + swap → bird_y=232, lose=0, pipes at 640/980.
- ce=0 for 20 cycles mid-DRAW → no op_wr_en, all outputs and state hold.
